uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the UART link. It sits directly downstream of the transmitter, either at the far end of the `tx` line or in loopback. It samples the asynchronous `rx` line at mid-bit using a clock-cycle baud counter, with the same bit timing the transmitter uses. It deserialises 8N1 frames, LSB first, and delivers each byte on a parallel port with a single-cycle valid strobe. Framing errors and line breaks are flagged.

## Interface
- `BAUD_RATE`, 115_200 — line bit rate.
- `CLOCK_SPEED`, 50_000_000 — `clk` frequency in Hz.
- `clk`  in  1  — single clock for all logic.
- `rst`  in  1  — reset, synchronous, active-high; one clock, sampled on the rising edge.
- `rx`  in  1  — asynchronous serial line; idles high.
- `data`  out  8  — last good byte; reset 0x00.
- `rx_valid`  out  1  — one-cycle pulse when `data` updates; reset 0.
- `frame_err`  out  1  — one-cycle pulse when a stop bit is sampled low; reset 0.
- `parity_err`  out  1  — one-cycle pulse on parity mismatch; reset 0; constant 0 without the macro.
- `rx_busy`  out  1  — high when state ≠ IDLE; reset 0.

## Operation
- Constants: `BAUD_WIDTH = CLOCK_SPEED / BAUD_RATE` (434 at defaults); `HALF = BAUD_WIDTH / 2` (217).
- Baud counter is 9 bits and counts 0 … `BAUD_WIDTH-1`. A counter "tick" is the edge at which the count equals `BAUD_WIDTH-1`; the count returns to 0 on that edge.
- `rx` passes through a 2-flop synchroniser whose flops reset to 1. Its output is `rx_s`. All decisions use `rx_s`.
- **IDLE**: if `rx_s == 0`, go to START with counter = 0.
- **START**: count up. At count `HALF-1`:
  - `rx_s == 1` → glitch; return to IDLE with no output pulse.
  - otherwise → DATA, counter = 0, `bit_idx = 0`.
- **DATA**: on each tick, shift `rx_s` into `shreg[bit_idx]` (LSB first) and increment `bit_idx`. After bit 7 → STOP (PARITY if enabled).
- **PARITY**: on the tick, capture the parity bit and go to STOP.
- **STOP**: on the tick:
  - `rx_s == 1` → `data <= shreg`, pulse `rx_valid`, pulse `parity_err` on mismatch (the byte is still delivered); go to IDLE.
  - `rx_s == 0` → pulse `frame_err`; `data` and `rx_valid` are untouched; go to BREAK.
- **BREAK**: wait until `rx_s == 1`, then go to IDLE. A held-low line produces exactly one `frame_err`.
- `data` holds its value until the next good frame. There is no backpressure: the consumer must take `data` within one frame time.
- Reset mid-frame: all state, counter, `bit_idx` and outputs are cleared on the next edge, and the partial byte is discarded. If the line is still low after reset, it is treated as a start bit. The result is normally a `frame_err` followed by BREAK.

## Timing
- Edge 0 is the first edge at which `rx` is low. At defaults:
  - START is entered on edge 2.
  - The start check happens on edge `2+HALF` (219).
  - Bit n is sampled on edge `2+HALF+(n+1)·BAUD_WIDTH`.
  - The stop bit is sampled on edge `2+HALF+9·BAUD_WIDTH` (4125).
- `rx_valid` and `frame_err` are high for the single cycle after the stop-sample edge. Enabling parity adds `BAUD_WIDTH` cycles.
- `rx_busy` rises after edge 2 and falls with the `rx_valid` edge.
- Back-to-back frames: the receiver is back in IDLE `HALF` cycles before the earliest next start edge, so no frame is lost.
- Tolerates ±4 % baud mismatch, limited by the mid-bit sampling margin.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - One even-parity bit is expected between D7 and stop.
  - A mismatch sets `parity_err` on the stop-sample cycle, together with `rx_valid` or `frame_err`.
- Undefined:
  - 8N1 framing; the PARITY state is not built.
  - `parity_err` is tied to 0.

## Structure
- Shared package `uart_pkg`: the state enum (IDLE, START, DATA, PARITY, STOP, BREAK) and a function returning `BAUD_WIDTH` from the two parameters. Both `uart_rx` and the transmitter's bench models use the package.
- Sub-module `uart_sync2`: the 2-flop synchroniser, reset value 1.

## Test plan
- Reset held 5 cycles with `rx` high → all outputs 0 and `rx_busy` 0. Idle for 10 000 cycles → no pulses.
- Frame 0xA5 at 434 cycles/bit → `rx_valid` for one cycle at edge 4125, `data == 0xA5`, `frame_err` 0.
- Low glitch of 100 cycles on an idle line → return to IDLE at edge 219; no `rx_valid`; `data` unchanged.
- Frame with stop bit 0, then line held low for 3 frames → exactly one `frame_err`, no `rx_valid`, `data` keeps its previous value. IDLE is re-entered 2 cycles after the line goes high.
- Back-to-back 0x00, 0xFF, 0x3C with no idle gap, sourced by the transmitter block at matching parameters → three `rx_valid` pulses with correct bytes. Repeat with the sender's baud ±3 % → same result.
- With `UART_RX_PARITY_EN`: 0x07 sent with parity 1 → `rx_valid` only. The same frame with parity 0 → `rx_valid` and `parity_err` together, `data == 0x07`.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and baud arithmetic shared by the UART receiver and its bench models.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    function automatic int baud_width(input int clock_speed, input int baud_rate);
        return clock_speed / baud_rate;
    endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, parallel byte and status strobes out.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    modport master (input rx, output data, rx_valid, frame_err, parity_err, rx_busy);
    modport slave (output rx, input data, rx_valid, frame_err, parity_err, rx_busy);
endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an idle-high asynchronous line; flops reset to 1.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) r_sync <= 2'b11;
        else r_sync <= {r_sync[0], i_d};
    end

    assign o_q = r_sync[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, mid-bit sampling, framing-error and break detection.
// Define UART_RX_PARITY_EN to expect an even-parity bit between D7 and the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_RATE   = 115_200,
    parameter int CLOCK_SPEED = 50_000_000
) (
    input logic       clk,
    input logic       rst,
    uart_rx_if.master bus
);
    localparam int BAUD_WIDTH = baud_width(CLOCK_SPEED, BAUD_RATE);
    localparam logic [8:0] TICK = 9'(BAUD_WIDTH - 1);
    localparam logic [8:0] HALF_M1 = 9'(BAUD_WIDTH / 2 - 1);

    state_t     r_state;
    logic [8:0] r_cnt;
    logic [2:0] r_idx;
    logic [7:0] r_shreg;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_ferr;
    logic       r_perr;
    logic       r_busy;
    logic       w_rx_s;
    logic       w_tick;
    logic       w_par_bad;

    uart_sync2 u_sync (.clk(clk), .rst(rst), .i_d(bus.rx), .o_q(w_rx_s));

    assign w_tick = r_cnt == TICK;
`ifdef UART_RX_PARITY_EN
    logic r_par;
    assign w_par_bad = r_par != ^r_shreg;
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            r_cnt   <= w_tick ? '0 : r_cnt + 9'd1;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end
                // a start bit that is high again at its midpoint was only a glitch
                START: if (r_cnt == HALF_M1) begin
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_state <= w_rx_s ? IDLE : DATA;
                    r_busy  <= !w_rx_s;
                end
                DATA: if (w_tick) begin
                    r_shreg[r_idx] <= w_rx_s;
                    r_idx <= r_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (r_idx == 3'd7) r_state <= PARITY;
`else
                    if (r_idx == 3'd7) r_state <= STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (w_tick) begin
                    r_par   <= w_rx_s;
                    r_state <= STOP;
                end
`endif
                STOP: if (w_tick) begin
                    r_perr  <= w_par_bad;
                    r_valid <= w_rx_s;
                    r_ferr  <= !w_rx_s;
                    if (w_rx_s) r_data <= r_shreg;
                    r_state <= w_rx_s ? IDLE : BREAK;
                    r_busy  <= !w_rx_s;
                end
                BREAK: begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.data       = r_data;
    assign bus.rx_valid   = r_valid;
    assign bus.frame_err  = r_ferr;
    assign bus.parity_err = r_perr;
    assign bus.rx_busy    = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames (with optional even parity) and checks received bytes and strobes.
module tb_uart_rx;
    localparam int BW = 434;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int NB = 10;
    localparam bit PAR = 1'b0;
`endif
    localparam int FR = NB * BW;
    localparam int STOP_OFF = 2 + BW / 2 + (NB - 1) * BW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int last_valid = 0;
    logic [8:0] obs_q[$];
    logic [8:0] exp_q[$];

    uart_rx_if bus();
    uart_rx #(.BAUD_RATE(115_200), .CLOCK_SPEED(50_000_000)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            n_valid++;
            last_valid = cyc;
            obs_q.push_back({bus.parity_err, bus.data});
        end
        if (bus.frame_err) n_ferr++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] obs_at(input int i);
        return i < obs_q.size() ? obs_q[i] : 9'h1FF;
    endfunction

    task automatic at_edge(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // frame bits LSB first: start, D0..D7, [even parity ^ flip], stop
    task automatic send_frame(input logic [7:0] b, input int per, input logic stop, input logic flip);
        logic [10:0] bits;
        bits = PAR ? {stop, (^b) ^ flip, b, 1'b0} : {1'b0, stop, b, 1'b0};
        for (int i = 0; i < NB; i++) begin
            bus.rx = bits[i];
            idle(per);
        end
    endtask

    initial begin
        int v0, f0, t0, h;
        logic [7:0] b;
        logic fl;
        logic [7:0] fixed[3];
        int pers[3];
        fixed = '{8'h00, 8'hFF, 8'h3C};
        pers = '{BW, 447, 421};
        bus.rx = 1'b1;
        idle(5);
        rst = 1'b0;
        check("rst_data", bus.data, 0);
        check("rst_valid", bus.rx_valid, 0);
        check("rst_ferr", bus.frame_err, 0);
        check("rst_perr", bus.parity_err, 0);
        check("rst_busy", bus.rx_busy, 0);
        v0 = n_valid; f0 = n_ferr;
        idle(10000);
        check("idle_valid", n_valid - v0, 0);
        check("idle_ferr", n_ferr - f0, 0);

        v0 = n_valid; f0 = n_ferr; obs_q.delete();
        t0 = cyc + 1;
        fork
            send_frame(8'hA5, BW, 1'b1, 1'b0);
            begin
                at_edge(t0 + 1);
                check("a5_busy_pre", bus.rx_busy, 0);
                at_edge(t0 + 2);
                check("a5_busy_start", bus.rx_busy, 1);
            end
        join
        idle(BW);
        check("a5_count", n_valid - v0, 1);
        check("a5_data", obs_at(0), {1'b0, 8'hA5});
        check("a5_time", last_valid - t0, STOP_OFF);
        check("a5_ferr", n_ferr - f0, 0);
        check("a5_busy_end", bus.rx_busy, 0);

        v0 = n_valid;
        t0 = cyc + 1;
        bus.rx = 1'b0;
        idle(100);
        bus.rx = 1'b1;
        at_edge(t0 + 218);
        check("glitch_busy_in", bus.rx_busy, 1);
        at_edge(t0 + 219);
        check("glitch_busy_out", bus.rx_busy, 0);
        idle(BW);
        check("glitch_valid", n_valid - v0, 0);
        check("glitch_data", bus.data, 8'hA5);

        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h5A, BW, 1'b0, 1'b0);
        idle(3 * FR);
        h = cyc;
        bus.rx = 1'b1;
        at_edge(h + 2);
        check("brk_busy_hold", bus.rx_busy, 1);
        at_edge(h + 3);
        check("brk_busy_idle", bus.rx_busy, 0);
        check("brk_ferr", n_ferr - f0, 1);
        check("brk_valid", n_valid - v0, 0);
        check("brk_data", bus.data, 8'hA5);

        v0 = n_valid; f0 = n_ferr;
        bus.rx = 1'b0;
        idle(1500);
        rst = 1'b1;
        bus.rx = 1'b1;
        idle(1);
        rst = 1'b0;
        check("mid_rst_busy", bus.rx_busy, 0);
        check("mid_rst_data", bus.data, 0);
        idle(1000);
        check("mid_rst_valid", n_valid - v0, 0);
        check("mid_rst_ferr", n_ferr - f0, 0);

        for (int p = 0; p < 3; p++) begin
            obs_q.delete(); exp_q.delete(); f0 = n_ferr;
            for (int i = 0; i < (p == 0 ? 4 : 3); i++) begin
                b = i < 3 ? fixed[i] : 8'($urandom);
                fl = PAR ? 1'($urandom_range(0, 1)) : 1'b0;
                exp_q.push_back({fl, b});
                send_frame(b, pers[p], 1'b1, fl);
            end
            bus.rx = 1'b1;
            idle(BW);
            check("b2b_count", obs_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) check("b2b_byte", obs_at(i), exp_q[i]);
            check("b2b_ferr", n_ferr - f0, 0);
        end

        if (PAR) begin
            obs_q.delete();
            send_frame(8'h07, BW, 1'b1, 1'b0);
            send_frame(8'h07, BW, 1'b1, 1'b1);
            idle(BW);
            check("par_good", obs_at(0), {1'b0, 8'h07});
            check("par_bad", obs_at(1), {1'b1, 8'h07});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
